// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS-style control unit:
// FSM states, instruction classes, opcode/funct values and datapath select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX   = 4'd2,
    S_MEM  = 4'd3,
    S_WB   = 4'd4,
    S_BR   = 4'd5,
    S_JMP  = 4'd6,
    S_JR   = 4'd7,
    S_MULW = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_MUL,
    CL_LOAD,
    CL_STORE,
    CL_IMM,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_JALR,
    CL_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MUL   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MUL   = 6'h02;

  // ALUOp[2:0] codes; ALUOp[3] carries OpCode[0] for signed/unsigned variants
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_MUL   = 3'b110;
  localparam logic [2:0] ALU_OR    = 3'b111;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_REG    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT  = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_BRANCH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_TARGET = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WBSRC_ALU = 2'd0;
  localparam logic [1:0] WBSRC_MEM = 2'd1;
  localparam logic [1:0] WBSRC_PC  = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_op_msb;
    logic       illegal;
    logic       done;
  } ctrl_t;

  function automatic logic is_shift_funct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational decode of OpCode/Funct into an instruction class, the ALUOp
// low bits and the immediate-extension controls.
module instr_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         shift,
  output logic [2:0]   alu_op,
  output logic         ext_op,
  output logic         lu_op
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    cls    = CL_ILLEGAL;
    shift  = 1'b0;
    alu_op = ALU_ADD;
    ext_op = 1'b1;
    lu_op  = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          cls = CL_JR;
        end else if (funct == FN_JALR) begin
          cls = CL_JALR;
        end else begin
          cls    = CL_RTYPE;
          alu_op = ALU_FUNCT;
          shift  = is_shift_funct(funct);
        end
      end
      OP_MUL: begin
        if (funct == FN_MUL) begin
          cls    = CL_MUL;
          alu_op = ALU_MUL;
        end
      end
      OP_LW:              cls = CL_LOAD;
      OP_SW:              cls = CL_STORE;
      OP_BEQ: begin
        cls    = CL_BEQ;
        alu_op = ALU_SUB;
      end
      OP_J:               cls = CL_J;
      OP_JAL:             cls = CL_JAL;
      OP_ADDI, OP_ADDIU:  cls = CL_IMM;
      OP_ANDI: begin
        cls    = CL_IMM;
        alu_op = ALU_AND;
        ext_op = 1'b0;
      end
      OP_ORI: begin
        cls    = CL_IMM;
        alu_op = ALU_OR;
        ext_op = 1'b0;
      end
      OP_SLTI, OP_SLTIU: begin
        cls    = CL_IMM;
        alu_op = ALU_SLT;
      end
      OP_LUI: begin
        cls   = CL_IMM;
        lu_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables and mux selects, with a retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 32,
  parameter int ALUOP_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal,
  output logic               instr_done,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t             state_q, state_d;
  logic [5:0]         op_q, funct_q;
  logic [3:0]         mul_cnt_q;
  logic [CNT_W-1:0]   cnt_q;
  ctrl_t              ctrl;

  logic [5:0]         dec_op, dec_funct;
  instr_class_t       cls;
  logic               shift;
  logic [2:0]         alu_op;
  logic               ext_op, lu_op;

  // ID decides on the instruction register directly; later states use the copy taken on ID exit.
  assign dec_op    = (state_q == S_ID) ? OpCode : op_q;
  assign dec_funct = (state_q == S_ID) ? Funct  : funct_q;

  instr_class_decode u_decode (
    .op     (dec_op),
    .funct  (dec_funct),
    .cls    (cls),
    .shift  (shift),
    .alu_op (alu_op),
    .ext_op (ext_op),
    .lu_op  (lu_op)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        unique case (cls)
          CL_BEQ:                                      state_d = S_BR;
          CL_J, CL_JAL:                                state_d = S_JMP;
          CL_JR, CL_JALR:                              state_d = S_JR;
          CL_RTYPE, CL_MUL, CL_LOAD, CL_STORE, CL_IMM: state_d = S_EX;
          default:                                     state_d = S_IF;
        endcase
      end
      S_EX: begin
        if (cls == CL_MUL)                             state_d = (MUL_CYCLES > 1) ? S_MULW : S_WB;
        else if (cls == CL_LOAD || cls == CL_STORE)    state_d = S_MEM;
        else                                           state_d = S_WB;
      end
      S_MULW: if (mul_cnt_q == 4'd1) state_d = S_WB;
      S_MEM:  if (mem_ready) state_d = (cls == CL_STORE) ? S_IF : S_WB;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_ID: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.illegal   = (cls == CL_ILLEGAL);
      end
      S_EX: begin
        ctrl.alu_src_a  = shift ? SRCA_SHAMT : SRCA_REG;
        ctrl.alu_src_b  = (cls == CL_RTYPE || cls == CL_MUL) ? SRCB_REG : SRCB_IMM;
        ctrl.alu_op     = alu_op;
        ctrl.alu_op_msb = op_q[0];
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls == CL_LOAD);
        ctrl.mem_write = (cls == CL_STORE);
        ctrl.done      = (cls == CL_STORE) && mem_ready;
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (cls == CL_RTYPE || cls == CL_MUL) ? REGDST_RD : REGDST_RT;
        ctrl.mem_to_reg = (cls == CL_LOAD) ? WBSRC_MEM : WBSRC_ALU;
        ctrl.done       = 1'b1;
      end
      S_BR: begin
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_TARGET;
        ctrl.alu_op        = alu_op;
        ctrl.alu_op_msb    = op_q[0];
        ctrl.done          = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.done      = 1'b1;
        if (cls == CL_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REGDST_RA;
          ctrl.mem_to_reg = WBSRC_PC;
        end
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REG;
        ctrl.done      = 1'b1;
        if (cls == CL_JALR) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REGDST_RD;
          ctrl.mem_to_reg = WBSRC_PC;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      funct_q   <= '0;
      mul_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q    <= OpCode;
        funct_q <= Funct;
      end
      if (state_q == S_EX && state_d == S_MULW) mul_cnt_q <= MUL_LOAD;
      else if (state_q == S_MULW)               mul_cnt_q <= mul_cnt_q - 4'd1;
      if (ctrl.done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // NOTE: enables and pulses are gated by reset itself, not just by the IF state it forces,
  // so nothing writes while reset is held.
  assign PCWrite     = ctrl.pc_write      & ~reset;
  assign PCWriteCond = ctrl.pc_write_cond & ~reset;
  assign IRWrite     = ctrl.ir_write      & ~reset;
  assign MemRead     = ctrl.mem_read      & ~reset;
  assign MemWrite    = ctrl.mem_write     & ~reset;
  assign RegWrite    = ctrl.reg_write     & ~reset;
  assign illegal     = ctrl.illegal       & ~reset;
  assign instr_done  = ctrl.done          & ~reset;

  assign IorD     = ctrl.i_or_d;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign PCSource = ctrl.pc_source;
  assign ExtOp    = ext_op;
  assign LuOp     = lu_op;

  always_comb begin
    ALUOp      = '0;
    ALUOp[3:0] = {ctrl.alu_op_msb, ctrl.alu_op};
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each issued instruction pushes its per-cycle expected
// state and outputs; the drain loop drives inputs and compares every cycle.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int MC_A = 4;
  localparam int MC_B = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       Zero, mem_ready;

  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp, LuOp, illegal, instr_done;
  logic [3:0] ALUOp, state, instr_count;

  logic        b_PCWrite, b_PCWriteCond, b_IorD, b_IRWrite, b_MemRead, b_MemWrite, b_RegWrite;
  logic [1:0]  b_RegDst, b_MemtoReg, b_ALUSrcA, b_ALUSrcB, b_PCSource;
  logic        b_ExtOp, b_LuOp, b_illegal, b_instr_done;
  logic [3:0]  b_ALUOp, b_state;
  logic [31:0] b_instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.MUL_CYCLES(MC_A), .CNT_W(4), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ExtOp(ExtOp), .LuOp(LuOp), .ALUOp(ALUOp), .illegal(illegal), .instr_done(instr_done),
    .state(state), .instr_count(instr_count)
  );

  multicycle_control #(.MUL_CYCLES(MC_B), .CNT_W(32), .ALUOP_W(4)) dut_b (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD), .IRWrite(b_IRWrite),
    .MemRead(b_MemRead), .MemWrite(b_MemWrite), .RegWrite(b_RegWrite),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .PCSource(b_PCSource), .ExtOp(b_ExtOp), .LuOp(b_LuOp), .ALUOp(b_ALUOp),
    .illegal(b_illegal), .instr_done(b_instr_done), .state(b_state), .instr_count(b_instr_count)
  );

  typedef enum {K_ADD, K_SLL, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_MUL, K_ILL} kind_e;

  typedef struct {
    logic [5:0]  op, fn;
    logic        mr, z, alt;
    state_t      st;
    logic [6:0]  we;
    logic [13:0] sel;
    logic        done, ill, ext, lu;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_cnt  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] kop(input kind_e k);
    case (k)
      K_ORI: return 6'h0d;
      K_LUI: return 6'h0f;
      K_LW:  return 6'h23;
      K_SW:  return 6'h2b;
      K_BEQ: return 6'h04;
      K_J:   return 6'h02;
      K_JAL: return 6'h03;
      K_MUL: return 6'h1c;
      K_ILL: return 6'h3f;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] kfn(input kind_e k);
    case (k)
      K_ADD: return 6'h20;
      K_MUL: return 6'h02;
      default: return 6'h00;
    endcase
  endfunction

  // {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite}
  function automatic logic [6:0] exp_we(input kind_e k, input state_t s, input logic mr);
    case (s)
      S_IF:  return {mr, 1'b0, 1'b0, mr, 1'b1, 1'b0, 1'b0};
      S_MEM: return {3'b001, 1'b0, k == K_LW, k == K_SW, 1'b0};
      S_WB:  return 7'b0000001;
      S_BR:  return 7'b0100000;
      S_JMP: return {1'b1, 5'b00000, k == K_JAL};
      default: return 7'b0;
    endcase
  endfunction

  // {ALUOp, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource}
  function automatic logic [13:0] exp_sel(input kind_e k, input state_t s);
    logic [3:0] a;
    logic [1:0] sa, sbb, rd, mt, pc;
    a = '0; sa = '0; sbb = '0; rd = '0; mt = '0; pc = '0;
    case (s)
      S_IF: sbb = 2'd1;
      S_ID: sbb = 2'd3;
      S_EX: begin
        sa  = (k == K_SLL) ? 2'd2 : 2'd1;
        sbb = (k inside {K_ADD, K_SLL, K_MUL}) ? 2'd0 : 2'd2;
        case (k)
          K_ADD, K_SLL:       a = 4'b0010;
          K_ORI:              a = 4'b1111;
          K_LUI, K_LW, K_SW:  a = 4'b1000;
          K_MUL:              a = 4'b0110;
          default:            a = 4'b0000;
        endcase
      end
      S_WB: begin
        rd = (k inside {K_ADD, K_SLL, K_MUL}) ? 2'd1 : 2'd0;
        mt = (k == K_LW) ? 2'd1 : 2'd0;
      end
      S_BR: begin
        a  = 4'b0001;
        pc = 2'd1;
      end
      S_JMP: begin
        pc = 2'd2;
        if (k == K_JAL) begin
          rd = 2'd2;
          mt = 2'd2;
        end
      end
      default: ;
    endcase
    return {a, sa, sbb, rd, mt, pc};
  endfunction

  task automatic push(input kind_e k, input state_t s, input logic mr, input logic z, input logic alt);
    exp_t e;
    e.op   = kop(k);
    e.fn   = kfn(k);
    e.mr   = mr;
    e.z    = z;
    e.alt  = alt;
    e.st   = s;
    e.we   = exp_we(k, s, mr);
    e.sel  = exp_sel(k, s);
    e.done = (s inside {S_WB, S_BR, S_JMP}) || (s == S_MEM && k == K_SW && mr);
    e.ill  = (s == S_ID) && (k == K_ILL);
    e.ext  = (k != K_ORI);
    e.lu   = (k == K_LUI);
    sb.push_back(e);
  endtask

  // mem_ready is held high outside IF/MEM to show it is ignored there
  task automatic issue(input kind_e k, input int mem_wait, input logic z, input logic alt);
    int mc;
    mc = alt ? MC_B : MC_A;
    push(k, S_IF, 1'b1, z, alt);
    push(k, S_ID, 1'b1, z, alt);
    case (k)
      K_ADD, K_SLL, K_ORI, K_LUI: begin
        push(k, S_EX, 1'b1, z, alt);
        push(k, S_WB, 1'b1, z, alt);
      end
      K_LW, K_SW: begin
        push(k, S_EX, 1'b1, z, alt);
        for (int i = 0; i < mem_wait; i++) push(k, S_MEM, 1'b0, z, alt);
        push(k, S_MEM, 1'b1, z, alt);
        if (k == K_LW) push(k, S_WB, 1'b1, z, alt);
      end
      K_BEQ:      push(k, S_BR, 1'b1, z, alt);
      K_J, K_JAL: push(k, S_JMP, 1'b1, z, alt);
      K_MUL: begin
        push(k, S_EX, 1'b1, z, alt);
        for (int i = 0; i < mc - 1; i++) push(k, S_MULW, 1'b1, z, alt);
        push(k, S_WB, 1'b1, z, alt);
      end
      default: ;
    endcase
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      OpCode    = e.op;
      Funct     = e.fn;
      mem_ready = e.mr;
      Zero      = e.z;
      #1;
      if (e.alt) begin
        check("state", 32'(b_state), 32'(e.st));
        check("enables", 32'({b_PCWrite, b_PCWriteCond, b_IorD, b_IRWrite, b_MemRead, b_MemWrite, b_RegWrite}), 32'(e.we));
        check("selects", 32'({b_ALUOp, b_ALUSrcA, b_ALUSrcB, b_RegDst, b_MemtoReg, b_PCSource}), 32'(e.sel));
        check("instr_done", 32'(b_instr_done), 32'(e.done));
        check("illegal", 32'(b_illegal), 32'(e.ill));
      end else begin
        check("state", 32'(state), 32'(e.st));
        check("enables", 32'({PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite}), 32'(e.we));
        check("selects", 32'({ALUOp, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource}), 32'(e.sel));
        check("instr_done", 32'(instr_done), 32'(e.done));
        check("illegal", 32'(illegal), 32'(e.ill));
        check("instr_count", 32'(instr_count), 32'(exp_cnt));
        if (e.st == S_EX) begin
          check("ExtOp", 32'(ExtOp), 32'(e.ext));
          check("LuOp", 32'(LuOp), 32'(e.lu));
        end
        if (e.done) exp_cnt = exp_cnt + 4'd1;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    OpCode    = '0;
    Funct     = '0;
    Zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'(S_IF));
    check("reset_count", 32'(instr_count), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("reset_enables", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
    check("reset_pulses", 32'({illegal, instr_done}), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    issue(K_ADD, 0, 1'b0, 1'b0);
    issue(K_SLL, 0, 1'b0, 1'b0);
    issue(K_ORI, 0, 1'b0, 1'b0);
    issue(K_LUI, 0, 1'b0, 1'b0);
    issue(K_LW,  3, 1'b0, 1'b0);
    issue(K_SW,  1, 1'b0, 1'b0);
    issue(K_BEQ, 0, 1'b0, 1'b0);
    issue(K_BEQ, 0, 1'b1, 1'b0);
    issue(K_J,   0, 1'b0, 1'b0);
    issue(K_JAL, 0, 1'b0, 1'b0);
    issue(K_MUL, 0, 1'b0, 1'b0);
    issue(K_ILL, 0, 1'b0, 1'b0);
    issue(K_ADD, 0, 1'b0, 1'b0);
    drain();

    // sw stalled in MEM, then reset lands mid-cycle
    push(K_SW, S_IF,  1'b1, 1'b0, 1'b0);
    push(K_SW, S_ID,  1'b1, 1'b0, 1'b0);
    push(K_SW, S_EX,  1'b1, 1'b0, 1'b0);
    push(K_SW, S_MEM, 1'b0, 1'b0, 1'b0);
    drain();
    #2;
    reset = 1'b1;
    #1;
    check("abort_memwrite", 32'(MemWrite), 32'd0);
    check("abort_enables", 32'({PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite}), 32'd0);
    check("abort_state", 32'(state), 32'(S_IF));
    check("abort_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset     = 1'b0;
    exp_cnt   = '0;

    for (int i = 0; i < 16; i++) issue(K_ADD, 0, 1'b0, 1'b0);
    issue(K_ILL, 0, 1'b0, 1'b0);
    drain();
    check("count_wrap", 32'(instr_count), 32'd0);

    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    issue(K_MUL, 0, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
